// File: rtl/aes_pkg.sv
// AES shared definitions: FSM encodings, GF(2^8) arithmetic, S-box maths, byte slicing.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package aes_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } fsm_t;

    // Round count for a given key length (10/12/14).
    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    // Byte at row r, column c; byte 0 sits in the MSBs of the block.
    function automatic logic [7:0] byte_of(input logic [127:0] s, input int r, input int c);
        return s[127 - 8 * (4 * c + r) -: 8];
    endfunction

    // Multiply by x modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiplies used by (Inv)MixColumns, built from chained xtime.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h2:    return x2;
            4'h3:    return x2 ^ b;
            4'h9:    return x8 ^ b;
            4'hb:    return x8 ^ x2 ^ b;
            4'hd:    return x8 ^ x4 ^ b;
            4'he:    return x8 ^ x4 ^ x2;
            default: return b;
        endcase
    endfunction

    // General GF(2^8) multiply, only needed for the field inverse below.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Field inverse as a^254: six square-and-multiply steps give a^127, then square.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        p = a;
        for (int i = 0; i < 6; i++) p = gf_mul(gf_mul(p, p), a);
        return gf_mul(p, p);
    endfunction

    // Forward S-box: inverse followed by the affine map.
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map followed by the field inverse.
    function automatic logic [7:0] inv_sub_byte(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One full AES round, forward or inverse, final-round variant via 'last'.
// Latency: combinational.
// Backpressure: none.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         decrypt,
    input  logic         last,
    output logic [127:0] next_state
);
    logic [127:0] sub, inv_sub;
    logic [127:0] shifted, inv_shifted;
    logic [127:0] mixed, inv_mixed, dec_key;

    // Byte substitution commutes with the row rotation, so both run on the raw state.
    for (genvar c = 0; c < 4; c++) begin : g_col
        s_box     u_sbox  (.x(state[127-32*c -: 32]), .y(sub[127-32*c -: 32]));
        inv_s_box u_isbox (.x(state[127-32*c -: 32]), .y(inv_sub[127-32*c -: 32]));
    end

    // Row rotations: forward pulls from column c+r, inverse from column c-r
    always_comb begin
        shifted     = '0;
        inv_shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8]     = byte_of(sub, r, (c + r) % 4);
                inv_shifted[127-8*(4*c+r) -: 8] = byte_of(inv_sub, r, (c + 4 - r) % 4);
            end
        end
    end

    assign dec_key = inv_shifted ^ round_key;

    // Column mixing; the inverse path mixes after the key add
    always_comb begin
        mixed     = '0;
        inv_mixed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mixed[127-8*(4*c+r) -: 8] =
                    gmul(byte_of(shifted, r, c), 4'h2) ^
                    gmul(byte_of(shifted, (r + 1) % 4, c), 4'h3) ^
                    byte_of(shifted, (r + 2) % 4, c) ^
                    byte_of(shifted, (r + 3) % 4, c);
                inv_mixed[127-8*(4*c+r) -: 8] =
                    gmul(byte_of(dec_key, r, c), 4'he) ^
                    gmul(byte_of(dec_key, (r + 1) % 4, c), 4'hb) ^
                    gmul(byte_of(dec_key, (r + 2) % 4, c), 4'hd) ^
                    gmul(byte_of(dec_key, (r + 3) % 4, c), 4'h9);
            end
        end
    end

    assign next_state = decrypt ? (last ? dec_key : inv_mixed)
                                : ((last ? shifted : mixed) ^ round_key);
endmodule

// File: rtl/inv_s_box.sv
// Inverse AES S-box, four bytes side by side.
// Latency: combinational.
// Backpressure: none.
module inv_s_box
    import aes_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);
    // Substitute each byte independently
    always_comb begin
        y = '0;
        for (int i = 0; i < 4; i++) y[8*i +: 8] = inv_sub_byte(x[8*i +: 8]);
    end
endmodule

// File: rtl/s_box.sv
// Forward AES S-box, four bytes side by side.
// Latency: combinational.
// Backpressure: none.
module s_box
    import aes_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);
    // Substitute each byte independently
    always_comb begin
        y = '0;
        for (int i = 0; i < 4; i++) y[8*i +: 8] = sub_byte(x[8*i +: 8]);
    end
endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per clock.
// Latency: out_valid rises NR cycles after the accept edge; one block per NR+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter  int KEY_BITS = 128,
    localparam int NR       = nr_of(KEY_BITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [128*(NR+1)-1:0]   w,
    input  logic [127:0]            in_data,
    input  logic                    in_decrypt,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [127:0]            out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_cipher_core: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [3:0] NR4 = 4'(NR);

    fsm_t         st, st_nxt;
    logic [3:0]   rc;
    logic [3:0]   rk_idx;
    logic         mode;
    logic         accept;
    logic         last;
    logic [127:0] blk;
    logic [127:0] round_key;
    logic [127:0] acc_key;
    logic [127:0] round_out;

    // Decrypt walks the key schedule backwards; keys are read straight from w.
    assign last      = (rc == NR4);
    assign rk_idx    = mode ? (NR4 - rc) : rc;
    assign round_key = w[128*rk_idx +: 128];
    assign acc_key   = in_decrypt ? w[128*NR +: 128] : w[127:0];

    aes_round u_round (
        .state      (blk),
        .round_key  (round_key),
        .decrypt    (mode),
        .last       (last),
        .next_state (round_out)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= st_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        st_nxt    = IDLE;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    st_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                st_nxt = last ? DONE : RUN;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                st_nxt    = out_ready ? IDLE : DONE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Datapath: initial key add on accept, one round per RUN cycle, capture the final round
    always_ff @(posedge clk) begin
        if (reset) begin
            blk      <= '0;
            rc       <= '0;
            mode     <= 1'b0;
            out_data <= '0;
        end else if (accept) begin
            blk  <= in_data ^ acc_key;
            rc   <= 4'd1;
            mode <= in_decrypt;
        end else if (st == RUN) begin
            blk <= round_out;
            if (last) out_data <= round_out;
            else      rc       <= rc + 4'd1;
        end
    end
endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: one instance per key size, FIPS-197 vectors, corner sequences, random traffic.
// Latency: expected results are queued at accept and compared at the output handshake.
// Backpressure: out_ready is held low or randomised per phase.
module tb_aes_cipher_core;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1919:0] w          [3];
    logic [127:0]  in_data    [3];
    logic          in_decrypt [3];
    logic          in_valid   [3];
    logic          out_ready  [3];
    wire           in_ready   [3];
    wire           out_valid  [3];
    wire           busy       [3];
    wire  [127:0]  out_data   [3];

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [3][$];
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Shift-and-add multiply with explicit 0x11b reduction
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // S-box table by walking generator 3 and its inverse together
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sbox[p] = x;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = i[7:0];
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Key expansion; key words are taken from the top of a 256-bit vector
    function automatic logic [1919:0] expand(input logic [255:0] key, input int kb);
        logic [31:0]   wd [60];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [1919:0] res;
        int nk, nr;
        nk   = kb / 32;
        nr   = nk + 6;
        rcon = 8'h01;
        res  = '0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                wd[i] = key[255 - 32*i -: 32];
            end else begin
                tmp = wd[i-1];
                if (i % nk == 0) begin
                    tmp  = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                    rcon = mul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                wd[i] = wd[i-nk] ^ tmp;
            end
            res[128*(i/4) + 127 - 32*(i%4) -: 32] = wd[i];
        end
        return res;
    endfunction

    // Reference cipher / inverse cipher on a 16-byte array (index 4*col+row)
    function automatic logic [127:0] model_cipher(input logic [1919:0] wk, input int nr,
                                                  input logic dec, input logic [127:0] blk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        int rki;
        rki = dec ? nr : 0;
        for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8] ^ wk[128*rki + 127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            if (!dec) begin
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++) t[4*c+j] = sbox[s[4*((c+j)%4)+j]];
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[4*c+j] = ((r == nr) ? t[4*c+j] :
                                    (mul(t[4*c+j], 8'h02) ^ mul(t[4*c+(j+1)%4], 8'h03) ^
                                     t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4]))
                                   ^ wk[128*r + 127 - 8*(4*c+j) -: 8];
            end else begin
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        t[4*c+j] = isbox[s[4*((c+4-j)%4)+j]] ^ wk[128*(nr-r) + 127 - 8*(4*c+j) -: 8];
                for (int c = 0; c < 4; c++)
                    for (int j = 0; j < 4; j++)
                        s[4*c+j] = (r == nr) ? t[4*c+j] :
                                   (mul(t[4*c+j], 8'h0e) ^ mul(t[4*c+(j+1)%4], 8'h0b) ^
                                    mul(t[4*c+(j+2)%4], 8'h0d) ^ mul(t[4*c+(j+3)%4], 8'h09));
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int KB  = 128 + 64 * k;
        localparam int NRK = KB / 32 + 6;
        logic [127:0] exp_v;

        aes_cipher_core #(.KEY_BITS(KB)) dut (
            .clk        (clk),
            .reset      (reset),
            .w          (w[k][128*(NRK+1)-1:0]),
            .in_data    (in_data[k]),
            .in_decrypt (in_decrypt[k]),
            .in_valid   (in_valid[k]),
            .in_ready   (in_ready[k]),
            .out_data   (out_data[k]),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready[k]),
            .busy       (busy[k])
        );

        // Scoreboard push: handshake seen before the coming edge
        always @(negedge clk) begin
            if (!reset && in_valid[k] && in_ready[k])
                exp_q[k].push_back(model_cipher(w[k], NRK, in_decrypt[k], in_data[k]));
        end

        // Scoreboard pop and compare at the output handshake
        always @(negedge clk) begin
            if (!reset && out_valid[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid[%0d]: out_valid with no accepted block", k);
                end else if (out_ready[k]) begin
                    exp_v = exp_q[k].pop_front();
                    chk($sformatf("sb_out[%0d]", k), out_data[k], exp_v);
                end
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, input logic dec);
        logic acc;
        acc = 1'b0;
        in_data[k]    = d;
        in_decrypt[k] = dec;
        in_valid[k]   = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready[k] && !reset;
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        chk($sformatf("accepted[%0d]", k), 128'(acc), 128'(1));
    endtask

    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (!out_valid[k] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 300 && exp_q[k].size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk($sformatf("drain[%0d]", k), 128'(exp_q[k].size()), 128'(0));
    endtask

    typedef struct {
        int           k;
        logic         dec;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    initial begin
        vec_t          vt [6];
        logic [255:0]  key;
        logic [127:0]  d;
        int            n, k, cyc;
        int            acc_t [$];

        build_sbox();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]   = 1'b0;
            in_data[i]    = '0;
            in_decrypt[i] = 1'b0;
            out_ready[i]  = 1'b1;
            key = '0;
            for (int b = 0; b < (128 + 64*i) / 8; b++) key[255 - 8*b -: 8] = b[7:0];
            w[i] = expand(key, 128 + 64*i);
        end

        vt[0] = '{0, 1'b0, PT,    CT128};
        vt[1] = '{1, 1'b0, PT,    CT192};
        vt[2] = '{2, 1'b0, PT,    CT256};
        vt[3] = '{0, 1'b1, CT128, PT};
        vt[4] = '{1, 1'b1, CT192, PT};
        vt[5] = '{2, 1'b1, CT256, PT};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i),  128'(in_ready[i]),  128'(1));
            chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("rst_busy[%0d]", i),      128'(busy[i]),      128'(0));
            chk($sformatf("rst_out_data[%0d]", i),  out_data[i],        128'(0));
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        // FIPS-197 vectors, with in_decrypt flipped right after accept
        for (int v = 0; v < 6; v++) begin
            k = vt[v].k;
            send(k, vt[v].din, vt[v].dec);
            in_decrypt[k] = ~vt[v].dec;
            wait_valid(k, n);
            chk($sformatf("latency[%0d]", v), 128'(n), 128'(10 + 2*k));
            chk($sformatf("vec_out[%0d]", v), out_data[k], vt[v].dout);
            @(posedge clk);
            #1;
            chk($sformatf("vec_one_cycle_valid[%0d]", v), 128'(out_valid[k]), 128'(0));
            chk($sformatf("vec_in_ready_back[%0d]", v),   128'(in_ready[k]),  128'(1));
        end

        // Output backpressure with an ignored in_valid pulse
        out_ready[0] = 1'b0;
        send(0, PT, 1'b0);
        wait_valid(0, n);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_data[0]  = 128'hdeadbeef_00000000_cafef00d_12345678;
                in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold[%0d]", i),      out_data[0],            CT128);
            chk($sformatf("bp_valid[%0d]", i),     128'(out_valid[0]),     128'(1));
            chk($sformatf("bp_in_ready[%0d]", i),  128'(in_ready[0]),      128'(0));
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready",  128'(in_ready[0]),  128'(1));
        chk("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
        chk("bp_release_busy",      128'(busy[0]),      128'(0));
        chk("bp_queue_empty",       128'(exp_q[0].size()), 128'(0));

        // Back-to-back throughput on AES-192: one accept every NR+2 cycles
        in_data[1]    = PT;
        in_decrypt[1] = 1'b0;
        in_valid[1]   = 1'b1;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (in_ready[1]) acc_t.push_back(cyc);
            @(posedge clk);
            #1;
        end
        in_valid[1] = 1'b0;
        chk("b2b_count", 128'(acc_t.size()), 128'(5));
        for (int i = 1; i < acc_t.size(); i++)
            chk($sformatf("b2b_gap[%0d]", i), 128'(acc_t[i] - acc_t[i-1]), 128'(14));
        drain(1);
        @(posedge clk);
        #1;

        // Reset in the middle of an AES-256 block
        send(2, PT, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy_before_reset", 128'(busy[2]), 128'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q[2].delete();
        chk("mid_rst_in_ready",  128'(in_ready[2]),  128'(1));
        chk("mid_rst_out_valid", 128'(out_valid[2]), 128'(0));
        chk("mid_rst_busy",      128'(busy[2]),      128'(0));
        chk("mid_rst_out_data",  out_data[2],        128'(0));
        send(2, PT, 1'b0);
        wait_valid(2, n);
        chk("mid_after_latency", 128'(n), 128'(14));
        chk("mid_after_out",     out_data[2], CT256);
        @(posedge clk);
        #1;

        // Random keys, blocks and modes with random gaps and output stalls
        for (int t = 0; t < 1000; t++) begin
            k = $urandom_range(0, 2);
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            w[k] = expand(key, 128 + 64*k);
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            out_ready[k] = 1'($urandom_range(0, 1));
            send(k, d, 1'($urandom_range(0, 1)));
            for (int i = 0; i < 200 && exp_q[k].size() != 0; i++) begin
                out_ready[k] = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            chk($sformatf("rand_done[%0d]", t), 128'(exp_q[k].size()), 128'(0));
            out_ready[k] = 1'b1;
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
